// File: rtl/op_encoder_issue.sv
// Encodes a control-signal bundle into the 6-bit opcode the control unit decodes,
// buffers legal opcodes in a small FIFO and issues them over valid/ready; illegal bundles are counted.
module op_encoder_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_regWrite,
    input  logic                     in_memWrite,
    input  logic                     in_memRead,
    input  logic                     in_ALU_src,
    input  logic [3:0]               in_ALU_op,
    input  logic [1:0]               in_kind,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_op,
    output logic                     illegal,
    output logic [CNT_W-1:0]         illegal_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_BEQ = 4'd8;
    localparam logic [3:0] ALU_BNE = 4'd9;
    localparam logic [3:0] ALU_BLT = 4'd10;
    localparam logic [3:0] ALU_BGE = 4'd11;
    localparam logic [3:0] ALU_NOP = 4'd12;

    logic [9:0]    key;
    logic [5:0]    enc_op;
    logic          enc_legal;
    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [LW-1:0] count;
    logic          push;
    logic          drop;
    logic          pop;

    assign key = {in_regWrite, in_memWrite, in_memRead, in_ALU_src, in_ALU_op, in_kind};

    // Key layout: {regWrite, memWrite, memRead, ALU_src, ALU_op, kind}
    always_comb begin
        enc_op    = 6'd0;
        enc_legal = 1'b1;
        case (key)
            {4'b1000, ALU_ADD, 2'd0}: enc_op = 6'd0;
            {4'b1001, ALU_ADD, 2'd0}: enc_op = 6'd1;
            {4'b1000, ALU_SUB, 2'd0}: enc_op = 6'd2;
            {4'b1000, ALU_AND, 2'd0}: enc_op = 6'd3;
            {4'b1001, ALU_AND, 2'd0}: enc_op = 6'd4;
            {4'b1000, ALU_OR,  2'd0}: enc_op = 6'd5;
            {4'b1001, ALU_OR,  2'd0}: enc_op = 6'd6;
            {4'b1000, ALU_XOR, 2'd0}: enc_op = 6'd7;
            {4'b1000, ALU_SLL, 2'd0}: enc_op = 6'd8;
            {4'b1000, ALU_SRL, 2'd0}: enc_op = 6'd9;
            {4'b1000, ALU_SRA, 2'd0}: enc_op = 6'd10;
            {4'b1011, ALU_ADD, 2'd0}: enc_op = 6'd11;
            {4'b0101, ALU_ADD, 2'd0}: enc_op = 6'd12;
            {4'b1000, ALU_BEQ, 2'd0}: enc_op = 6'd13;
            {4'b1000, ALU_BNE, 2'd0}: enc_op = 6'd14;
            {4'b1000, ALU_BLT, 2'd0}: enc_op = 6'd15;
            {4'b1000, ALU_BGE, 2'd0}: enc_op = 6'd16;
            {4'b1000, ALU_ADD, 2'd1}: enc_op = 6'd17;
            {4'b1000, ALU_ADD, 2'd2}: enc_op = 6'd18;
            {4'b0000, ALU_NOP, 2'd0}: enc_op = 6'd19;
            default:                  enc_legal = 1'b0;
        endcase
    end

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign level     = count;
    assign push      = in_valid && in_ready && enc_legal;
    assign drop      = in_valid && in_ready && !enc_legal;
    assign pop       = out_valid && out_ready;
    assign rd_next   = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc_op;
    end

    // out_op is a register tracking the next head so it holds the last popped value when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_op      <= 6'd0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                if (count > LW'(1))
                    out_op <= mem[rd_next];
                else if (push)
                    out_op <= enc_op;
            end else if (count == '0 && push) begin
                out_op <= enc_op;
            end
            if (drop) begin
                illegal <= 1'b1;
                if (illegal_cnt != '1)
                    illegal_cnt <= illegal_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_op_encoder_issue.sv
// Directed bench for op_encoder_issue: issue order, back-pressure, illegal counting,
// counter saturation (second instance with CNT_W=2), pointer wrap and asynchronous reset.
module tb_op_encoder_issue;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] XOR = 4'd4;
    localparam logic [3:0] SLL = 4'd5;
    localparam logic [3:0] SRL = 4'd6;
    localparam logic [3:0] SRA = 4'd7;
    localparam logic [3:0] BEQ = 4'd8;
    localparam logic [3:0] BNE = 4'd9;
    localparam logic [3:0] BLT = 4'd10;
    localparam logic [3:0] BGE = 4'd11;
    localparam logic [3:0] NOP = 4'd12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_valid2 = 1'b0;
    logic       in_regWrite = 1'b0;
    logic       in_memWrite = 1'b0;
    logic       in_memRead = 1'b0;
    logic       in_ALU_src = 1'b0;
    logic [3:0] in_ALU_op = 4'd0;
    logic [1:0] in_kind = 2'd0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, illegal;
    logic [5:0] out_op;
    logic [7:0] illegal_cnt;
    logic [2:0] level;
    logic       in_ready2, out_valid2, illegal2;
    logic [5:0] out_op2;
    logic [1:0] illegal_cnt2;
    logic [2:0] level2;

    logic [9:0] lkey [20];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    op_encoder_issue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_regWrite(in_regWrite), .in_memWrite(in_memWrite), .in_memRead(in_memRead),
        .in_ALU_src(in_ALU_src), .in_ALU_op(in_ALU_op), .in_kind(in_kind),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .illegal(illegal), .illegal_cnt(illegal_cnt), .level(level)
    );

    op_encoder_issue #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_regWrite(in_regWrite), .in_memWrite(in_memWrite), .in_memRead(in_memRead),
        .in_ALU_src(in_ALU_src), .in_ALU_op(in_ALU_op), .in_kind(in_kind),
        .out_valid(out_valid2), .out_ready(1'b1), .out_op(out_op2),
        .illegal(illegal2), .illegal_cnt(illegal_cnt2), .level(level2)
    );

    function automatic logic [9:0] mk(input logic [3:0] ctl, input logic [3:0] op, input logic [1:0] kind);
        return {ctl, op, kind};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [9:0] k);
        {in_regWrite, in_memWrite, in_memRead, in_ALU_src, in_ALU_op, in_kind} = k;
    endtask

    // Legal table: entry i encodes to opcode i.
    task automatic init_tables();
        lkey[0]  = mk(4'b1000, ADD, 2'd0);
        lkey[1]  = mk(4'b1001, ADD, 2'd0);
        lkey[2]  = mk(4'b1000, SUB, 2'd0);
        lkey[3]  = mk(4'b1000, AND, 2'd0);
        lkey[4]  = mk(4'b1001, AND, 2'd0);
        lkey[5]  = mk(4'b1000, OR,  2'd0);
        lkey[6]  = mk(4'b1001, OR,  2'd0);
        lkey[7]  = mk(4'b1000, XOR, 2'd0);
        lkey[8]  = mk(4'b1000, SLL, 2'd0);
        lkey[9]  = mk(4'b1000, SRL, 2'd0);
        lkey[10] = mk(4'b1000, SRA, 2'd0);
        lkey[11] = mk(4'b1011, ADD, 2'd0);
        lkey[12] = mk(4'b0101, ADD, 2'd0);
        lkey[13] = mk(4'b1000, BEQ, 2'd0);
        lkey[14] = mk(4'b1000, BNE, 2'd0);
        lkey[15] = mk(4'b1000, BLT, 2'd0);
        lkey[16] = mk(4'b1000, BGE, 2'd0);
        lkey[17] = mk(4'b1000, ADD, 2'd1);
        lkey[18] = mk(4'b1000, ADD, 2'd2);
        lkey[19] = mk(4'b0000, NOP, 2'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid, out_op, level} !== {1'b1, 1'b0, 6'd0, 3'd0})
            $display("[TB] FAIL reset_fifo: got rdy=%0b vld=%0b op=%0d lvl=%0d, want 1 0 0 0", in_ready, out_valid, out_op, level);
        else passes++;
        checks++;
        if ({illegal, illegal_cnt} !== {1'b0, 8'd0})
            $display("[TB] FAIL reset_illegal: got %0b/%0d, want 0/0", illegal, illegal_cnt);
        else passes++;
    endtask

    task automatic test_issue();
        int idx [7] = '{0, 1, 11, 12, 17, 18, 19};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_bundle(lkey[idx[i]]);
            in_valid = 1'b1;
            step();
            checks++;
            if ({out_valid, out_op, level} !== {1'b1, 6'(idx[i]), 3'd1})
                $display("[TB] FAIL issue_%0d: got vld=%0b op=%b lvl=%0d, want 1 %b 1", i, out_valid, out_op, level, 6'(idx[i]));
            else passes++;
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, out_op, level} !== {1'b0, 6'd19, 3'd0})
            $display("[TB] FAIL issue_drain: got vld=%0b op=%b lvl=%0d, want 0 010011 0", out_valid, out_op, level);
        else passes++;
    endtask

    task automatic test_backpressure();
        int idx [5] = '{2, 3, 5, 7, 8};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_bundle(lkey[idx[i]]);
            in_valid = 1'b1;
            step();
            checks++;
            if ({level, in_ready, out_op} !== {3'(i < 4 ? i + 1 : 4), (i < 3), 6'd2})
                $display("[TB] FAIL bp_fill_%0d: got lvl=%0d rdy=%0b op=%0d, want %0d %0b 2", i, level, in_ready, out_op, (i < 4 ? i + 1 : 4), (i < 3));
            else passes++;
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_op, level, in_ready} !== {6'd3, 3'd3, 1'b1})
            $display("[TB] FAIL bp_drain1: got op=%0d lvl=%0d rdy=%0b, want 3 3 1", out_op, level, in_ready);
        else passes++;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_op, level} !== {6'd5, 3'd3})
            $display("[TB] FAIL bp_drain2: got op=%0d lvl=%0d, want 5 3", out_op, level);
        else passes++;
        step();
        checks++;
        if ({out_op, level} !== {6'd7, 3'd2})
            $display("[TB] FAIL bp_drain3: got op=%0d lvl=%0d, want 7 2", out_op, level);
        else passes++;
        step();
        checks++;
        if ({out_op, level} !== {6'd8, 3'd1})
            $display("[TB] FAIL bp_drain4: got op=%0d lvl=%0d, want 8 1", out_op, level);
        else passes++;
        step();
        checks++;
        if ({out_valid, level} !== {1'b0, 3'd0})
            $display("[TB] FAIL bp_empty: got vld=%0b lvl=%0d, want 0 0", out_valid, level);
        else passes++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_bundle(mk(4'b0100, ADD, 2'd0));
        in_valid = 1'b1;
        step();
        checks++;
        if ({illegal, illegal_cnt, out_valid, in_ready} !== {1'b1, 8'd1, 1'b0, 1'b1})
            $display("[TB] FAIL illegal_stw: got ill=%0b cnt=%0d vld=%0b rdy=%0b, want 1 1 0 1", illegal, illegal_cnt, out_valid, in_ready);
        else passes++;
        set_bundle(mk(4'b1000, SUB, 2'd2));
        step();
        in_valid = 1'b0;
        checks++;
        if ({illegal, illegal_cnt, out_valid, level} !== {1'b1, 8'd2, 1'b0, 3'd0})
            $display("[TB] FAIL illegal_subjalr: got ill=%0b cnt=%0d vld=%0b lvl=%0d, want 1 2 0 0", illegal, illegal_cnt, out_valid, level);
        else passes++;
        step();
        checks++;
        if ({illegal_cnt, out_valid} !== {8'd2, 1'b0})
            $display("[TB] FAIL illegal_idle: got cnt=%0d vld=%0b, want 2 0", illegal_cnt, out_valid);
        else passes++;
    endtask

    task automatic test_saturate();
        set_bundle(mk(4'b1000, ADD, 2'd3));
        in_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({illegal2, illegal_cnt2, out_valid2} !== {1'b1, 2'(i < 3 ? i + 1 : 3), 1'b0})
                $display("[TB] FAIL sat_%0d: got ill=%0b cnt=%0d vld=%0b, want 1 %0d 0", i, illegal2, illegal_cnt2, out_valid2, (i < 3 ? i + 1 : 3));
            else passes++;
        end
        in_valid2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_bundle(lkey[0]);
        step();
        set_bundle(lkey[1]);
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_bundle(lkey[k + 2]);
            step();
            checks++;
            if ({out_op, level} !== {6'(k + 1), 3'd2})
                $display("[TB] FAIL wrap_%0d: got op=%0d lvl=%0d, want %0d 2", k, out_op, level, k + 1);
            else passes++;
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_op, level} !== {6'd11, 3'd1})
            $display("[TB] FAIL wrap_tail: got op=%0d lvl=%0d, want 11 1", out_op, level);
        else passes++;
        step();
        checks++;
        if ({out_valid, level} !== {1'b0, 3'd0})
            $display("[TB] FAIL wrap_empty: got vld=%0b lvl=%0d, want 0 0", out_valid, level);
        else passes++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_bundle(lkey[i + 13]);
            step();
        end
        set_bundle(mk(4'b1111, ADD, 2'd0));
        step();
        in_valid = 1'b0;
        checks++;
        if ({level, illegal, illegal_cnt, out_op} !== {3'd3, 1'b1, 8'd3, 6'd13})
            $display("[TB] FAIL pre_reset: got lvl=%0d ill=%0b cnt=%0d op=%0d, want 3 1 3 13", level, illegal, illegal_cnt, out_op);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, level, illegal, illegal_cnt, out_op, in_ready} !== {1'b0, 3'd0, 1'b0, 8'd0, 6'd0, 1'b1})
            $display("[TB] FAIL async_reset: got vld=%0b lvl=%0d ill=%0b cnt=%0d op=%0d rdy=%0b, want 0 0 0 0 0 1", out_valid, level, illegal, illegal_cnt, out_op, in_ready);
        else passes++;
        step();
        rst = 1'b0;
    endtask

    initial begin
        init_tables();
        test_reset();
        test_issue();
        test_backpressure();
        test_illegal();
        test_saturate();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
